run_ctrl: RTL and testbench

//  Run controller sitting directly upstream of top_level.
//  - Accepts the bench's req/done handshake.
//  - Holds the core in reset for a fixed number of cycles, then releases it.
//  - Watches the core's prog_ctr for the halt address and counts executed cycles.
//  - Aborts runaway programs with a timeout.
//  - Owns the core's reset and produces the program-level done.

---
 rtl/run_ctrl.sv | 125 ++++++++++++
 tb/tb_run_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// Run controller upstream of the core: holds the core in reset on start, releases it,
// watches prog_ctr for the halt address, counts RUN cycles and aborts runaway programs.
module run_ctrl #(
  parameter int D       = 12,
  parameter int HALT_PC = 128,
  parameter int CW      = 16,
  parameter int MAX_CYC = 4000,
  parameter int RST_CYC = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [D-1:0]  prog_ctr,
  output logic          core_reset,
  output logic          core_en,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycle_cnt
);

  localparam int RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYC - 1);
  localparam logic [CW-1:0]  MAX_V    = CW'(MAX_CYC);
  localparam logic [D-1:0]   HALT_V   = D'(HALT_PC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RST  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [RCW-1:0] r_rst_cnt;
  logic [RCW-1:0] w_rst_cnt_next;
  logic [CW-1:0]  r_cycle_cnt;
  logic [CW-1:0]  w_cycle_cnt_next;
  logic [CW-1:0]  w_cycle_inc;
  logic           r_timeout;
  logic           w_timeout_next;
  logic           w_halt;
  logic           r_core_reset;
  logic           r_core_en;
  logic           r_busy;
  logic           r_done;

  assign w_halt      = (prog_ctr == HALT_V);
  assign w_cycle_inc = r_cycle_cnt + 1'b1;

  always_comb begin
    w_state_next     = r_state;
    w_rst_cnt_next   = r_rst_cnt;
    w_cycle_cnt_next = r_cycle_cnt;
    w_timeout_next   = r_timeout;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_state_next     = S_RST;
          w_rst_cnt_next   = '0;
          w_cycle_cnt_next = '0;
          w_timeout_next   = 1'b0;
        end
      end
      S_RST: begin
        if (r_rst_cnt == RST_LAST) begin
          w_state_next = S_RUN;
        end else begin
          w_rst_cnt_next = r_rst_cnt + 1'b1;
        end
      end
      S_RUN: begin
        // The halting cycle is still counted; halt takes priority over the limit.
        w_cycle_cnt_next = w_cycle_inc;
        if (w_halt) begin
          w_state_next   = S_DONE;
          w_timeout_next = 1'b0;
        end else if (w_cycle_inc == MAX_V) begin
          w_state_next   = S_DONE;
          w_timeout_next = 1'b1;
        end
      end
      S_DONE: begin
        if (!req) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_rst_cnt    <= '0;
      r_cycle_cnt  <= '0;
      r_timeout    <= 1'b0;
      r_core_reset <= 1'b1;
      r_core_en    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_rst_cnt    <= w_rst_cnt_next;
      r_cycle_cnt  <= w_cycle_cnt_next;
      r_timeout    <= w_timeout_next;
      r_core_reset <= (w_state_next == S_IDLE) || (w_state_next == S_RST);
      r_core_en    <= (w_state_next == S_RUN);
      r_busy       <= (w_state_next == S_RST) || (w_state_next == S_RUN);
      r_done       <= (w_state_next == S_DONE);
    end
  end

  assign core_reset = r_core_reset;
  assign core_en    = r_core_en;
  assign busy       = r_busy;
  assign done       = r_done;
  assign timeout    = r_timeout;
  assign cycle_cnt  = r_cycle_cnt;

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl: instance A uses default limits, instance B a 50-cycle limit.
module tb_run_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, req_a, core_reset_a, core_en_a, busy_a, done_a, timeout_a;
  logic [11:0] pc_a;
  logic [15:0] cnt_a;
  logic        rst_b, req_b, core_reset_b, core_en_b, busy_b, done_b, timeout_b;
  logic [11:0] pc_b;
  logic [15:0] cnt_b;

  run_ctrl u_dut_a (
    .clk(clk), .reset(rst_a), .req(req_a), .prog_ctr(pc_a),
    .core_reset(core_reset_a), .core_en(core_en_a), .busy(busy_a),
    .done(done_a), .timeout(timeout_a), .cycle_cnt(cnt_a)
  );

  run_ctrl #(.MAX_CYC(50)) u_dut_b (
    .clk(clk), .reset(rst_b), .req(req_b), .prog_ctr(pc_b),
    .core_reset(core_reset_b), .core_en(core_en_b), .busy(busy_b),
    .done(done_b), .timeout(timeout_b), .cycle_cnt(cnt_b)
  );

  // Core stubs: prog_ctr = RUN cycle index - 1 while the core is enabled.
  int pcnt_a = 0;
  int pcnt_b = 0;
  bit stuck_b = 1'b0;
  always @(posedge clk) begin
    pcnt_a <= core_en_a ? pcnt_a + 1 : 0;
    pcnt_b <= core_en_b ? pcnt_b + 1 : 0;
  end
  assign pc_a = 12'(pcnt_a);
  assign pc_b = stuck_b ? 12'd5 : ((pcnt_b == 49) ? 12'd128 : 12'(pcnt_b));

  typedef struct {
    string name;
    int    dut;
    int    fld;
    int    exp;
  } probe_t;

  typedef struct {
    bit to;
    int cnt;
  } run_exp_t;

  probe_t   q_probe[$];
  run_exp_t q_run_a[$];
  run_exp_t q_run_b[$];
  bit       end_flag = 1'b0;
  int       n_cmp = 0;
  int       n_err = 0;

  localparam int F_CRST = 0, F_EN = 1, F_BUSY = 2, F_DONE = 3, F_TO = 4, F_CNT = 5;

  function automatic int get_f(int dut, int fld);
    int v;
    v = 0;
    case (fld)
      F_CRST: v = (dut == 0) ? int'(core_reset_a) : int'(core_reset_b);
      F_EN:   v = (dut == 0) ? int'(core_en_a)    : int'(core_en_b);
      F_BUSY: v = (dut == 0) ? int'(busy_a)       : int'(busy_b);
      F_DONE: v = (dut == 0) ? int'(done_a)       : int'(done_b);
      F_TO:   v = (dut == 0) ? int'(timeout_a)    : int'(timeout_b);
      default: v = (dut == 0) ? int'(cnt_a)       : int'(cnt_b);
    endcase
    return v;
  endfunction

  task automatic cmp(string nm, int act, int ex);
    n_cmp++;
    if (act != ex) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, ex);
    end else begin
      $display("ok   %s = %0d", nm, act);
    end
  endtask

  task automatic probe(string nm, int dut, int fld, int ex);
    probe_t p;
    p.name = nm;
    p.dut  = dut;
    p.fld  = fld;
    p.exp  = ex;
    q_probe.push_back(p);
  endtask

  task automatic expect_run(int dut, bit to, int cnt);
    run_exp_t e;
    e.to  = to;
    e.cnt = cnt;
    if (dut == 0) q_run_a.push_back(e);
    else          q_run_b.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(int dut, int budget);
    int k;
    k = 0;
    while (get_f(dut, F_DONE) == 0 && k < budget) begin
      tick();
      k++;
    end
    if (get_f(dut, F_DONE) == 0) probe("done_within_budget", dut, F_DONE, 1);
  endtask

  // Monitor: the only process that compares and steps the counters.
  initial begin
    bit       prev_a, prev_b;
    probe_t   p;
    run_exp_t e;
    prev_a = 1'b0;
    prev_b = 1'b0;
    forever begin
      @(negedge clk);
      while (q_probe.size() > 0) begin
        p = q_probe.pop_front();
        cmp($sformatf("%s[dut%0d]", p.name, p.dut), get_f(p.dut, p.fld), p.exp);
      end
      if (done_a && !prev_a) begin
        if (q_run_a.size() == 0) cmp("unexpected_done[dut0]", 1, 0);
        else begin
          e = q_run_a.pop_front();
          cmp("run_timeout[dut0]", int'(timeout_a), int'(e.to));
          cmp("run_cycle_cnt[dut0]", int'(cnt_a), e.cnt);
        end
      end
      if (done_b && !prev_b) begin
        if (q_run_b.size() == 0) cmp("unexpected_done[dut1]", 1, 0);
        else begin
          e = q_run_b.pop_front();
          cmp("run_timeout[dut1]", int'(timeout_b), int'(e.to));
          cmp("run_cycle_cnt[dut1]", int'(cnt_b), e.cnt);
        end
      end
      prev_a = done_a;
      prev_b = done_b;
      if (end_flag) begin
        cmp("pending_runs", q_run_a.size() + q_run_b.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
      end
    end
  end

  // Stimulus
  initial begin
    rst_a = 1'b1; rst_b = 1'b1; req_a = 1'b0; req_b = 1'b0;
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      probe("rst_core_reset", d, F_CRST, 1);
      probe("rst_core_en", d, F_EN, 0);
      probe("rst_busy", d, F_BUSY, 0);
      probe("rst_done", d, F_DONE, 0);
      probe("rst_timeout", d, F_TO, 0);
      probe("rst_cycle_cnt", d, F_CNT, 0);
    end
    rst_a = 1'b0; rst_b = 1'b0;

    // Halt at prog_ctr 128 on RUN cycle 129
    req_a = 1'b1;
    expect_run(0, 1'b0, 129);
    tick();
    probe("rst1_core_reset", 0, F_CRST, 1);
    probe("rst1_busy", 0, F_BUSY, 1);
    tick();
    probe("rst2_core_reset", 0, F_CRST, 1);
    tick();
    probe("run1_core_reset", 0, F_CRST, 0);
    probe("run1_core_en", 0, F_EN, 1);
    wait_done(0, 300);

    // DONE holds while req stays high, then returns to IDLE and restarts
    for (int i = 0; i < 10; i++) begin
      tick();
      probe("hold_done", 0, F_DONE, 1);
    end
    probe("hold_core_en", 0, F_EN, 0);
    probe("hold_core_reset", 0, F_CRST, 0);
    req_a = 1'b0;
    tick();
    probe("idle_done", 0, F_DONE, 0);
    probe("idle_core_reset", 0, F_CRST, 1);
    probe("idle_cnt_kept", 0, F_CNT, 129);
    req_a = 1'b1;
    expect_run(0, 1'b0, 129);
    tick();
    probe("restart_cnt", 0, F_CNT, 0);
    probe("restart_busy", 0, F_BUSY, 1);
    wait_done(0, 300);
    req_a = 1'b0;
    tick();

    // Timeout with prog_ctr stuck
    stuck_b = 1'b1;
    req_b = 1'b1;
    expect_run(1, 1'b1, 50);
    wait_done(1, 100);
    probe("to_core_en", 1, F_EN, 0);
    req_b = 1'b0;
    tick();
    stuck_b = 1'b0;

    // Halt and limit on the same cycle: halt wins
    req_b = 1'b1;
    expect_run(1, 1'b0, 50);
    wait_done(1, 100);
    req_b = 1'b0;
    tick();

    // Reset in RUN cycle 20
    req_b = 1'b1;
    tick();
    tick();
    tick();
    probe("run_entry_en", 1, F_EN, 1);
    repeat (19) tick();
    probe("run20_cnt", 1, F_CNT, 19);
    rst_b = 1'b1;
    tick();
    probe("midrst_core_reset", 1, F_CRST, 1);
    probe("midrst_busy", 1, F_BUSY, 0);
    probe("midrst_cnt", 1, F_CNT, 0);
    probe("midrst_core_en", 1, F_EN, 0);
    rst_b = 1'b0;
    req_b = 1'b0;
    tick();
    probe("after_rst_busy", 1, F_BUSY, 0);
    tick();
    end_flag = 1'b1;
  end

endmodule
